alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The module SHALL have these ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req0, req1  input  1  requester n wants an ALU operation.
- mode0, mode1  input  4  requester n ALU mode code.
- opa0, opa1  input  8  requester n Operand1.
- opb0, opb1  input  8  requester n Operand2.
- upd0, upd1  input  1  requester n requests a status-flag update.
- gnt0, gnt1  output  1  one-cycle pulse; request n accepted.
- done0, done1  output  1  one-cycle pulse; result valid for requester n.
- result  output  8  captured ALU result.
- alu_mode  output  4  mode driven to the ALU.
- alu_op1, alu_op2  output  8  operands driven to the ALU.
- alu_out  input  8  ALU result.
- alu_flags  input  3  ALU flags {Z,C,S}.
- sreg  output  3  status register {Z,C,S}.
- busy  output  1  high in any state other than IDLE.

Function
REQ-002 The FSM SHALL have four states: IDLE, ISSUE, CAPTURE and DONE.
REQ-003 Transitions SHALL be:
- IDLE to ISSUE when req0 or req1 is high.
- ISSUE to CAPTURE unconditionally.
- CAPTURE to DONE unconditionally.
- DONE to IDLE unconditionally.
REQ-004 On the IDLE-to-ISSUE edge, the module SHALL latch the winner's mode, opa, opb and upd fields and the winner's index.
REQ-005 In ISSUE, the module SHALL pulse the winner's gnt for exactly one cycle.
REQ-006 alu_mode, alu_op1 and alu_op2 SHALL be driven from the latched registers, stable from ISSUE through CAPTURE, and SHALL be 0 in IDLE and DONE.
REQ-007 On the CAPTURE-to-DONE edge, the module SHALL register alu_out into result.
REQ-008 In DONE, the module SHALL pulse the winner's done for one cycle; result SHALL hold until the next capture.
REQ-009 Latency from req sampled high in IDLE to the done pulse SHALL be 3 cycles; throughput SHALL be one operation per 4 cycles.
REQ-010 Requests SHALL be sampled only in IDLE; a requester SHALL hold req until its gnt.
REQ-011 A req still high in the cycle after DONE SHALL be treated as a new request.
REQ-012 sreg SHALL update on the CAPTURE-to-DONE edge only when the latched upd is 1.
REQ-013 On such an update, Z and S SHALL always be loaded from alu_flags.
REQ-014 On such an update, C SHALL be loaded only for carry modes 0000, 0001, 0111, 1000, 1001 and 1111; for all other modes, C SHALL keep its previous value.
REQ-015 If req0 and req1 are both low in IDLE, the module SHALL remain in IDLE with no output change.

Reset
REQ-016 When rst_n is low, the module SHALL immediately force state=IDLE and set gnt, done, busy, result, sreg, alu_mode, alu_op1, alu_op2 and the priority pointer to 0, independent of clk.
REQ-017 Reset in any state SHALL abort the in-flight operation: no done pulse and no sreg update for it.
REQ-018 After rst_n rises, the first sampled request SHALL be served normally.

Configuration
REQ-019 With ALU_SEQ_RR_EN defined, the module SHALL use round-robin arbitration:
- When both requesters request, the one not served last SHALL win.
- The priority pointer SHALL update on each grant.
- Pointer reset value 0 SHALL give requester 0 first priority.
REQ-020 Without ALU_SEQ_RR_EN, the module SHALL use fixed priority: requester 0 SHALL always win ties, and no pointer register SHALL exist.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Single op: req0, mode=0000, opa=8'h0F, opb=8'h01, upd=1 -> gnt0 one cycle later, done0 3 cycles after sampling, result=8'h10, sreg=3'b000.
- Carry masking: req1, mode=0000, opa=8'hFF, opb=8'h01, upd=1 -> result=8'h00, sreg=3'b110; then req1, mode=0100, opa=8'hF0, opb=8'h0F, upd=1 -> result=8'h00, sreg=3'b110 with C retained.
- No update: req0, mode=0010, opa=8'h80, upd=0 -> result=8'h80, sreg unchanged.
- Contention: req0 and req1 held high continuously -> with ALU_SEQ_RR_EN, grant order 0,1,0,1; without it, 0,0,0; each done 4 cycles apart.
- Reset mid-operation: assert rst_n low during CAPTURE -> immediate IDLE, all outputs 0, no done pulse; the next req completes normally.
- Idle: no req for 10 cycles -> busy=0, alu_* remain 0, sreg unchanged.

Source files
------------

// File: rtl/alu_sequencer.sv
// Two-requester sequencer for an external ALU: IDLE→ISSUE→CAPTURE→DONE, done 3 cycles after req, one op per 4 cycles.
// Requesters hold req until gnt; arbitration is fixed priority, or round-robin when ALU_SEQ_RR_EN is defined.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] mode0,
  input  logic [3:0] mode1,
  input  logic [7:0] opa0,
  input  logic [7:0] opa1,
  input  logic [7:0] opb0,
  input  logic [7:0] opb1,
  input  logic       upd0,
  input  logic       upd1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result,
  output logic [3:0] alu_mode,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  input  logic [7:0] alu_out,
  input  logic [2:0] alu_flags,
  output logic [2:0] sreg,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        any_req, take, win_d;
  logic        win_q, upd_q;
  logic [3:0]  mode_q;
  logic [7:0]  opa_q, opb_q;
  logic [7:0]  result_q;
  logic [2:0]  sreg_q;

  // Modes whose carry flag is meaningful; all others leave C untouched.
  function automatic logic carry_mode(input logic [3:0] m);
    case (m)
      4'b0000, 4'b0001, 4'b0111,
      4'b1000, 4'b1001, 4'b1111: carry_mode = 1'b1;
      default:                   carry_mode = 1'b0;
    endcase
  endfunction

  assign any_req = req0 | req1;
  assign take    = (state_q == IDLE) && any_req;

`ifdef ALU_SEQ_RR_EN
  logic ptr_q;

  // ptr_q names the requester that wins a tie; it flips away from each winner.
  assign win_d = (req0 && req1) ? ptr_q : req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (take) begin
      ptr_q <= ~win_d;
    end
  end
`else
  assign win_d = ~req0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q  <= 1'b0;
      mode_q <= 4'd0;
      opa_q  <= 8'd0;
      opb_q  <= 8'd0;
      upd_q  <= 1'b0;
    end else if (take) begin
      win_q  <= win_d;
      mode_q <= win_d ? mode1 : mode0;
      opa_q  <= win_d ? opa1  : opa0;
      opb_q  <= win_d ? opb1  : opb0;
      upd_q  <= win_d ? upd1  : upd0;
    end
  end

  // Result and flags are taken on the CAPTURE-to-DONE edge; a reset before then drops the op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 8'd0;
      sreg_q   <= 3'd0;
    end else if (state_q == CAPTURE) begin
      result_q <= alu_out;
      if (upd_q) begin
        sreg_q[2] <= alu_flags[2];
        sreg_q[0] <= alu_flags[0];
        if (carry_mode(mode_q)) begin
          sreg_q[1] <= alu_flags[1];
        end
      end
    end
  end

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    done0    = 1'b0;
    done1    = 1'b0;
    alu_mode = 4'd0;
    alu_op1  = 8'd0;
    alu_op2  = 8'd0;
    busy     = (state_q != IDLE);
    case (state_q)
      ISSUE: begin
        gnt0     = ~win_q;
        gnt1     = win_q;
        alu_mode = mode_q;
        alu_op1  = opa_q;
        alu_op2  = opb_q;
      end
      CAPTURE: begin
        alu_mode = mode_q;
        alu_op1  = opa_q;
        alu_op2  = opb_q;
      end
      DONE: begin
        done0 = ~win_q;
        done1 = win_q;
      end
      default: ;
    endcase
  end

  assign result = result_q;
  assign sreg   = sreg_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus predicts each op's winner, result and status flags; a monitor checks done pulses.
module tb_alu_sequencer;

`ifdef ALU_SEQ_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       upd;
  } op_t;

  typedef struct {
    int         idx;
    logic [7:0] res;
    logic [2:0] sreg;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] mode0, mode1;
  logic [7:0] opa0, opa1, opb0, opb1;
  logic       upd0, upd1;
  logic       gnt0, gnt1, done0, done1;
  logic [7:0] result;
  logic [3:0] alu_mode;
  logic [7:0] alu_op1, alu_op2;
  logic [7:0] alu_out;
  logic [2:0] alu_flags;
  logic [2:0] sreg;
  logic       busy;
  logic [10:0] alu_r;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_gnt_cyc = 0;
  logic prev_gnt = 1'b0;
  exp_t sbq[$];
  exp_t mon_e;

  op_t        pend[2];
  bit         act[2];
  int         model_ptr;
  logic [2:0] model_sreg;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .mode0(mode0), .mode1(mode1),
    .opa0(opa0), .opa1(opa1),
    .opb0(opb0), .opb1(opb1),
    .upd0(upd0), .upd1(upd1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .result(result),
    .alu_mode(alu_mode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_out(alu_out), .alu_flags(alu_flags),
    .sreg(sreg), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Environment ALU: returns {Z,C,S,out}. Non-carry modes present a deliberately noisy C.
  function automatic logic [10:0] alu_fn(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] o;
    logic       c;
    c = ~(a[0] ^ b[0]);
    case (m)
      4'd0:  begin s = {1'b0, a} + {1'b0, b};         o = s[7:0]; c = s[8]; end
      4'd1:  begin o = a - b;                         c = (a < b); end
      4'd7:  begin s = {1'b0, a} + {1'b0, b} + 9'd1;  o = s[7:0]; c = s[8]; end
      4'd8:  begin o = {a[6:0], 1'b0};                c = a[7]; end
      4'd9:  begin o = {1'b0, a[7:1]};                c = a[0]; end
      4'd15: begin o = 8'h00 - a;                     c = (a != 8'h00); end
      4'd2:  o = a;
      4'd3:  o = b;
      4'd4:  o = a & b;
      4'd5:  o = a | b;
      4'd6:  o = a ^ b;
      default: o = ~(a ^ b);
    endcase
    return {(o == 8'h00), c, o[7], o};
  endfunction

  always_comb alu_r = alu_fn(alu_mode, alu_op1, alu_op2);
  assign alu_out   = alu_r[7:0];
  assign alu_flags = alu_r[10:8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic op_t mk(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b, input logic u);
    op_t o;
    o.mode = m; o.a = a; o.b = b; o.upd = u;
    return o;
  endfunction

  function automatic op_t rand_op();
    logic [3:0] m;
    logic [7:0] a, b;
    logic       u;
    m = 4'($urandom_range(15));
    a = 8'($urandom_range(255));
    b = 8'($urandom_range(255));
    u = 1'($urandom_range(1));
    return mk(m, a, b, u);
  endfunction

  task automatic drive();
    req0 = act[0]; mode0 = pend[0].mode; opa0 = pend[0].a; opb0 = pend[0].b; upd0 = pend[0].upd;
    req1 = act[1]; mode1 = pend[1].mode; opa1 = pend[1].a; opb1 = pend[1].b; upd1 = pend[1].upd;
  endtask

  // Predicts the winner among pending requests, queues its expected completion, waits for the grant.
  // Returns at the negedge inside CAPTURE.
  task automatic serve_one();
    int          w;
    logic [10:0] r;
    exp_t        e;
    bit          seen;
    if (act[0] && act[1]) w = RR ? model_ptr : 0;
    else                  w = act[0] ? 0 : 1;
    r = alu_fn(pend[w].mode, pend[w].a, pend[w].b);
    if (pend[w].upd) begin
      model_sreg[2] = r[10];
      model_sreg[0] = r[8];
      if (pend[w].mode inside {4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd15}) model_sreg[1] = r[9];
    end
    e.idx = w; e.res = r[7:0]; e.sreg = model_sreg;
    sbq.push_back(e);
    if (RR) model_ptr = 1 - w;
    drive();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = gnt0 | gnt1;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL gnt_timeout: got no grant expected gnt%0d", w);
      act[w] = 1'b0;
      drive();
      return;
    end
    chk("gnt_idx", {31'd0, gnt1}, w);
    chk("issue_alu_mode", alu_mode, pend[w].mode);
    chk("issue_alu_op1", alu_op1, pend[w].a);
    chk("issue_alu_op2", alu_op2, pend[w].b);
    act[w] = 1'b0;
    drive();
    @(negedge clk);
    chk("capture_alu_mode", alu_mode, pend[w].mode);
    chk("capture_alu_op1", alu_op1, pend[w].a);
    chk("capture_alu_op2", alu_op2, pend[w].b);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", sbq.size());
    end
  endtask

  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_alu_mode", alu_mode, 0);
      chk("idle_alu_op1", alu_op1, 0);
      chk("idle_alu_op2", alu_op2, 0);
      chk("idle_sreg", sreg, model_sreg);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected completion, two cycles after its grant.
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt0 || gnt1) begin
        chk("gnt_one_cycle", prev_gnt, 0);
        chk("gnt_onehot", gnt0 & gnt1, 0);
        last_gnt_cyc = cyc;
      end
      prev_gnt = gnt0 | gnt1;
      if (done0 || done1) begin
        chk("done_onehot", done0 & done1, 0);
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none", done0, done1);
        end else begin
          mon_e = sbq.pop_front();
          chk("done_idx", {31'd0, done1}, mon_e.idx);
          chk("result", result, mon_e.res);
          chk("sreg", sreg, mon_e.sreg);
          chk("gnt_to_done", cyc - last_gnt_cyc, 2);
          chk("done_alu_mode", alu_mode, 0);
        end
      end
    end else begin
      prev_gnt = 1'b0;
    end
  end

  initial begin
    int prev;
    rst_n = 1'b0;
    act[0] = 1'b0; act[1] = 1'b0;
    pend[0] = mk(4'd0, 8'd0, 8'd0, 1'b0);
    pend[1] = mk(4'd0, 8'd0, 8'd0, 1'b0);
    model_ptr = 0; model_sreg = 3'd0;
    drive();
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt0, gnt1, done0, done1}, 0);
    chk("rst_result", result, 0);
    chk("rst_sreg", sreg, 0);
    chk("rst_alu", {alu_mode, alu_op1, alu_op2}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single op
    pend[0] = mk(4'b0000, 8'h0F, 8'h01, 1'b1); act[0] = 1'b1;
    serve_one(); drain();
    chk("single_result", result, 8'h10);
    chk("single_sreg", sreg, 3'b000);

    // Carry masking
    pend[1] = mk(4'b0000, 8'hFF, 8'h01, 1'b1); act[1] = 1'b1;
    serve_one(); drain();
    chk("carry_result", result, 8'h00);
    chk("carry_sreg", sreg, 3'b110);
    pend[1] = mk(4'b0100, 8'hF0, 8'h0F, 1'b1); act[1] = 1'b1;
    serve_one(); drain();
    chk("mask_result", result, 8'h00);
    chk("mask_sreg", sreg, 3'b110);

    // No update
    pend[0] = mk(4'b0010, 8'h80, 8'h00, 1'b0); act[0] = 1'b1;
    serve_one(); drain();
    chk("noupd_result", result, 8'h80);
    chk("noupd_sreg", sreg, 3'b110);

    // Contention: both held continuously
    for (int j = 0; j < 2; j++) begin pend[j] = rand_op(); act[j] = 1'b1; end
    for (int k = 0; k < 5; k++) begin
      prev = last_gnt_cyc;
      serve_one();
      if (k > 0) chk("contention_gnt_spacing", last_gnt_cyc - prev, 4);
      for (int j = 0; j < 2; j++) if (!act[j]) begin pend[j] = rand_op(); act[j] = 1'b1; end
    end
    while (act[0] || act[1]) serve_one();
    drain();

    // Idle
    idle_chk(10);

    // Reset during CAPTURE
    pend[1] = mk(4'b0000, 8'hFF, 8'hFF, 1'b1); act[1] = 1'b1;
    serve_one();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_pulses", {gnt0, gnt1, done0, done1}, 0);
    chk("abort_result", result, 0);
    chk("abort_sreg", sreg, 0);
    chk("abort_alu", {alu_mode, alu_op1, alu_op2}, 0);
    sbq.delete();
    model_sreg = 3'd0; model_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_chk(3);
    pend[0] = mk(4'b0001, 8'h10, 8'h20, 1'b1); act[0] = 1'b1;
    serve_one(); drain();
    chk("post_reset_result", result, 8'hF0);
    chk("post_reset_sreg", sreg, 3'b011);

    // Randomized traffic
    for (int it = 0; it < 200; it++) begin
      for (int j = 0; j < 2; j++)
        if (!act[j] && $urandom_range(2) != 0) begin pend[j] = rand_op(); act[j] = 1'b1; end
      if (!act[0] && !act[1]) begin
        drain();
        idle_chk(int'($urandom_range(1, 4)));
        pend[it % 2] = rand_op(); act[it % 2] = 1'b1;
      end
      serve_one();
    end
    while (act[0] || act[1]) serve_one();
    drain();
    idle_chk(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
